// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU operand-issue / writeback stage:
// default sizes, FSM state encoding and symbolic ALU select codes.
package alu_issue_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;
  localparam int DEF_AW    = 3;

  // FSM state encoding
  localparam logic IDLE = 1'b0;
  localparam logic EXEC = 1'b1;

  // ALU select codes, shared with the ALU and its bench
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

endpackage

// File: rtl/alu_regfile.sv
// General register file: NREGS x WIDTH, cleared by synchronous reset,
// one synchronous write port and three combinational read ports.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    rs1_addr,
  output logic [WIDTH-1:0] rs1_data,
  input  logic [AW-1:0]    rs2_addr,
  output logic [WIDTH-1:0] rs2_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem_r [NREGS];

  // Storage: reset clears every entry, otherwise write one entry when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rs1_data = mem_r[rs1_addr];
  assign rs2_data = mem_r[rs2_addr];
  assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue and writeback stage around a combinational ALU.
// IDLE accepts an instruction and registers the ALU inputs; EXEC lasts one
// cycle, after which the ALU result is written back to the register file.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic             in_imm_en,
  input  logic [WIDTH-1:0] in_imm,
  output logic             alu_en,
  output logic [2:0]       alu_select,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  input  logic [WIDTH-1:0] alu_ans,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_rd,
  output logic [WIDTH-1:0] wb_data,
  input  logic [AW-1:0]    dbg_raddr,
  output logic [WIDTH-1:0] dbg_rdata
);

  logic             state_r;
  logic             next_state_s;
  logic             issue_s;
  logic             wb_s;
  logic [AW-1:0]    rd_r;
  logic [WIDTH-1:0] rs1_data_s;
  logic [WIDTH-1:0] rs2_data_s;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_s),
    .waddr    (rd_r),
    .wdata    (alu_ans),
    .rs1_addr (in_rs1),
    .rs1_data (rs1_data_s),
    .rs2_addr (in_rs2),
    .rs2_data (rs2_data_s),
    .dbg_addr (dbg_raddr),
    .dbg_data (dbg_rdata)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state: IDLE waits for a handshake, EXEC always returns to IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: ready depends on state only; issue/writeback strobes
  always_comb begin
    in_ready = 1'b0;
    issue_s  = 1'b0;
    wb_s     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        issue_s  = in_valid;
      end
      EXEC: begin
        wb_s = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Registered ALU inputs and writeback report; operands sampled at issue
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_en     <= 1'b0;
      alu_select <= 3'b000;
      alu_src1   <= {WIDTH{1'b0}};
      alu_src2   <= {WIDTH{1'b0}};
      rd_r       <= {AW{1'b0}};
      wb_valid   <= 1'b0;
      wb_rd      <= {AW{1'b0}};
      wb_data    <= {WIDTH{1'b0}};
    end else begin
      wb_valid <= 1'b0;
      if (issue_s) begin
        alu_src1   <= rs1_data_s;
        alu_src2   <= in_imm_en ? in_imm : rs2_data_s;
        alu_select <= in_op;
        alu_en     <= 1'b1;
        rd_r       <= in_rd;
      end else if (wb_s) begin
        alu_en   <= 1'b0;
        wb_valid <= 1'b1;
        wb_rd    <= rd_r;
        wb_data  <= alu_ans;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with a behavioural ALU model.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int A = DEF_AW;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [A-1:0] in_rd, in_rs1, in_rs2;
  logic         in_imm_en;
  logic [W-1:0] in_imm;
  logic         alu_en;
  logic [2:0]   alu_select;
  logic [W-1:0] alu_src1, alu_src2, alu_ans;
  logic         wb_valid;
  logic [A-1:0] wb_rd;
  logic [W-1:0] wb_data;
  logic [A-1:0] dbg_raddr;
  logic [W-1:0] dbg_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt;
  int wb_cnt;

  alu_issue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm_en  (in_imm_en),
    .in_imm     (in_imm),
    .alu_en     (alu_en),
    .alu_select (alu_select),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ans    (alu_ans),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural ALU feeding alu_ans
  always_comb begin
    alu_ans = 16'h0000;
    case (alu_select)
      ALU_ADD: alu_ans = alu_src1 + alu_src2;
      ALU_SUB: alu_ans = alu_src1 - alu_src2;
      ALU_AND: alu_ans = alu_src1 & alu_src2;
      ALU_OR:  alu_ans = alu_src1 | alu_src2;
      ALU_XOR: alu_ans = alu_src1 ^ alu_src2;
      ALU_NOT: alu_ans = ~alu_src1;
      ALU_SHL: alu_ans = alu_src1 << 1;
      ALU_SHR: alu_ans = alu_src1 >> 1;
      default: alu_ans = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [A-1:0] addr, input logic [W-1:0] exp);
    dbg_raddr = addr;
    #1;
    check(tag, {16'h0000, dbg_rdata}, {16'h0000, exp});
  endtask

  // Called at a negedge while IDLE; returns at the negedge inside EXEC
  task automatic issue(input logic [2:0] op, input logic [A-1:0] rd, input logic [A-1:0] rs1,
                       input logic [A-1:0] rs2, input logic imm_en, input logic [W-1:0] imm);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm_en = imm_en;
    in_imm    = imm;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'b000; in_rd = 3'd0; in_rs1 = 3'd0;
    in_rs2 = 3'd0; in_imm_en = 1'b0; in_imm = 16'h0000; dbg_raddr = 3'd0;

    // Reset
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_alu_en", {31'd0, alu_en}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    for (int i = 0; i < 8; i++) check_reg("rst_reg", i[A-1:0], 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Immediate issue: r1 = r0 + 0xF0F0
    issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'hF0F0);
    check("imm_alu_en", {31'd0, alu_en}, 32'd1);
    check("imm_src1", {16'h0000, alu_src1}, 32'h0000);
    check("imm_src2", {16'h0000, alu_src2}, 32'hF0F0);
    check("imm_ready", {31'd0, in_ready}, 32'd0);
    check_reg("imm_reg1_old", 3'd1, 16'h0000);
    @(negedge clk);
    check("imm_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("imm_wb_rd", {29'd0, wb_rd}, 32'd1);
    check("imm_wb_data", {16'h0000, wb_data}, 32'hF0F0);
    check_reg("imm_reg1", 3'd1, 16'hF0F0);
    check("imm_alu_en_off", {31'd0, alu_en}, 32'd0);

    // Preload r2 = 0x0F0F
    issue(ALU_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0F0F);
    @(negedge clk);
    check_reg("pre_reg2", 3'd2, 16'h0F0F);

    // Dependent back-to-back: r3 = r1 - r2 ; r4 = r3 + 1
    issue(ALU_SUB, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000);
    check("dep_sel", {29'd0, alu_select}, 32'd1);
    check("dep_src1", {16'h0000, alu_src1}, 32'hF0F0);
    check("dep_src2", {16'h0000, alu_src2}, 32'h0F0F);
    in_valid = 1'b1; in_op = ALU_ADD; in_rd = 3'd4; in_rs1 = 3'd3;
    in_rs2 = 3'd0; in_imm_en = 1'b1; in_imm = 16'h0001;
    @(negedge clk);
    check("dep_wb1_data", {16'h0000, wb_data}, 32'hE1E1);
    check("dep_wb1_rd", {29'd0, wb_rd}, 32'd3);
    check("dep_ready_again", {31'd0, in_ready}, 32'd1);
    check("dep_gap_en", {31'd0, alu_en}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("dep2_en", {31'd0, alu_en}, 32'd1);
    check("dep2_src1", {16'h0000, alu_src1}, 32'hE1E1);
    check("dep2_src2", {16'h0000, alu_src2}, 32'h0001);
    check("dep2_wb_pulse_gone", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("dep2_wb_data", {16'h0000, wb_data}, 32'hE1E2);
    check("dep2_wb_rd", {29'd0, wb_rd}, 32'd4);
    check_reg("dep_reg4", 3'd4, 16'hE1E2);
    @(negedge clk);

    // Stall: in_valid held high, r6 += 1 each accepted instruction
    hs_cnt = 0; wb_cnt = 0;
    in_valid = 1'b1; in_op = ALU_ADD; in_rd = 3'd6; in_rs1 = 3'd6;
    in_rs2 = 3'd0; in_imm_en = 1'b1; in_imm = 16'h0001;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) hs_cnt++;
      if (wb_valid) wb_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (wb_valid) wb_cnt++;
    check("stall_handshakes", hs_cnt, 32'd4);
    check("stall_wb_pulses", wb_cnt, 32'd4);
    @(negedge clk);
    check("stall_wb_done", {31'd0, wb_valid}, 32'd0);
    check_reg("stall_reg6", 3'd6, 16'h0004);

    // Self-overwrite: r5 = 1, then r5 = r5 + 1
    issue(ALU_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0001);
    @(negedge clk);
    issue(ALU_ADD, 3'd5, 3'd5, 3'd0, 1'b1, 16'h0001);
    @(negedge clk);
    check("self_wb_data", {16'h0000, wb_data}, 32'h0002);
    @(negedge clk); @(negedge clk);
    check_reg("self_reg5", 3'd5, 16'h0002);

    // Reset during EXEC abandons the writeback
    issue(ALU_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 16'hBEEF);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_en", {31'd0, alu_en}, 32'd0);
    for (int i = 0; i < 8; i++) check_reg("mid_rst_reg", i[A-1:0], 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_wb", {31'd0, wb_valid}, 32'd0);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check_reg("post_rst_reg7", 3'd7, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
